// File: rtl/irq_priority_controller_if.sv
// irq_priority_controller_if
// Bundles the control-unit handshake, interrupt lines and mask bus of the
// interrupt priority controller.
//   irq, nmi, cpu_busy, instr_boundary, int_ack, eret, mask_we, mask_wdata
//       : driven by the core / interrupt sources (master side)
//   int_req, int_nmi, int_id, vector, store_restore, in_service, mask
//       : driven by the controller (slave side)
interface irq_priority_controller_if #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
);
    logic [N_SRC-1:0] irq;
    logic             nmi;
    logic             cpu_busy;
    logic             instr_boundary;
    logic             int_ack;
    logic             eret;
    logic             mask_we;
    logic [N_SRC-1:0] mask_wdata;

    logic             int_req;
    logic             int_nmi;
    logic [ID_W-1:0]  int_id;
    logic [31:0]      vector;
    logic [1:0]       store_restore;
    logic             in_service;
    logic [N_SRC-1:0] mask;

    // Core / source side
    modport master (
        output irq, nmi, cpu_busy, instr_boundary, int_ack, eret, mask_we, mask_wdata,
        input  int_req, int_nmi, int_id, vector, store_restore, in_service, mask
    );

    // Controller side
    modport slave (
        input  irq, nmi, cpu_busy, instr_boundary, int_ack, eret, mask_we, mask_wdata,
        output int_req, int_nmi, int_id, vector, store_restore, in_service, mask
    );
endinterface

// File: rtl/irq_priority_controller.sv
// irq_priority_controller
// Fixed-priority interrupt controller for the multi-cycle MIPS core. Accepts
// N_SRC level-sensitive maskable lines (bit 0 highest priority) and one
// edge-detected NMI, requests service at instruction boundaries, sequences
// context store/restore and supplies the handler vector.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : irq_priority_controller_if.slave (handshake, lines, mask bus)
module irq_priority_controller #(
    parameter int          N_SRC         = 4,
    parameter int          ID_W          = 2,
    parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
    parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0010,
    parameter logic [31:0] NMI_VECTOR    = 32'h0000_0080
) (
    input logic                      clk,
    input logic                      reset,
    irq_priority_controller_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SAVE,
        SERVICE,
        RESTORE
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [N_SRC-1:0] mask_q;
    logic             nmi_d;
    logic             nmi_pend;
    logic             lat_nmi;
    logic [ID_W-1:0]  lat_id;
    logic [31:0]      lat_vec;

    logic [N_SRC-1:0] cand;
    logic             cand_any;
    logic [ID_W-1:0]  win_id;
    logic [31:0]      win_vec;
    logic             nmi_edge;
    logic             accept_nmi;
    logic             accept_irq;

    // Pick the lowest-indexed enabled line; scanning downward lets the
    // lowest set index overwrite any higher one.
    always_comb begin
        cand     = bus.irq & mask_q;
        cand_any = |cand;
        win_id   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_id = ID_W'(i);
            end
        end
        win_vec = VECTOR_BASE + (32'(win_id) * VECTOR_STRIDE);
    end

    // Acceptance is only possible at an instruction boundary in IDLE. A
    // pending NMI always wins and is not held off by cpu_busy.
    always_comb begin
        nmi_edge   = bus.nmi & ~nmi_d;
        accept_nmi = (state == IDLE) && bus.instr_boundary && nmi_pend;
        accept_irq = (state == IDLE) && bus.instr_boundary && !nmi_pend
                     && cand_any && !bus.cpu_busy;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. SAVE and RESTORE are single-cycle; no nesting while
    // a handler runs, so new events just wait in IDLE.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept_nmi || accept_irq) next_state = REQ;
            REQ:     if (bus.int_ack) next_state = SAVE;
            SAVE:    next_state = SERVICE;
            SERVICE: if (bus.eret) next_state = RESTORE;
            RESTORE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Mask, NMI edge detection and the request latch. A new NMI edge in the
    // same cycle as the NMI being accepted keeps the pending flag set, so
    // that edge is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q   <= '0;
            nmi_d    <= 1'b0;
            nmi_pend <= 1'b0;
            lat_nmi  <= 1'b0;
            lat_id   <= '0;
            lat_vec  <= '0;
        end else begin
            nmi_d <= bus.nmi;
            if (nmi_edge) begin
                nmi_pend <= 1'b1;
            end else if ((state == REQ) && bus.int_ack && lat_nmi) begin
                nmi_pend <= 1'b0;
            end
            if (bus.mask_we) begin
                mask_q <= bus.mask_wdata;
            end
            if (accept_nmi) begin
                lat_nmi <= 1'b1;
                lat_id  <= '0;
                lat_vec <= NMI_VECTOR;
            end else if (accept_irq) begin
                lat_nmi <= 1'b0;
                lat_id  <= win_id;
                lat_vec <= win_vec;
            end
        end
    end

    // Moore outputs. The latched request is only exposed outside IDLE so
    // the bus reads all-zero when nothing is being requested or serviced.
    always_comb begin
        bus.int_req       = (state == REQ);
        bus.in_service    = (state == SERVICE) || (state == RESTORE);
        bus.store_restore = 2'b00;
        if (state == SAVE) begin
            bus.store_restore = 2'b01;
        end else if (state == RESTORE) begin
            bus.store_restore = 2'b10;
        end
        bus.int_nmi = (state != IDLE) && lat_nmi;
        bus.int_id  = (state != IDLE) ? lat_id : '0;
        bus.vector  = (state != IDLE) ? lat_vec : '0;
        bus.mask    = mask_q;
    end

endmodule

// File: tb/tb_irq_priority_controller.sv
// tb_irq_priority_controller
// Directed bench for irq_priority_controller: mask writes, busy/mask
// blocking, full handshake, NMI priority and edge behaviour, NMI arriving
// during service, and reset in the middle of a context save.
module tb_irq_priority_controller;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    irq_priority_controller_if #(.N_SRC(4), .ID_W(2)) bus ();

    irq_priority_controller #(
        .N_SRC        (4),
        .ID_W         (2),
        .VECTOR_BASE  (32'h0000_0100),
        .VECTOR_STRIDE(32'h0000_0010),
        .NMI_VECTOR   (32'h0000_0080)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus.slave)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, clock once, and settle 1 ns after the edge
    // so outputs reflect the state entered on that edge.
    task automatic apply_stimulus(input logic [3:0] irq_v, input logic nmi_v,
                                  input logic busy_v, input logic bnd_v,
                                  input logic ack_v, input logic eret_v,
                                  input logic we_v, input logic [3:0] wdata_v);
        bus.irq            = irq_v;
        bus.nmi            = nmi_v;
        bus.cpu_busy       = busy_v;
        bus.instr_boundary = bnd_v;
        bus.int_ack        = ack_v;
        bus.eret           = eret_v;
        bus.mask_we        = we_v;
        bus.mask_wdata     = wdata_v;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;

        // Reset
        apply_stimulus(4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000);
        apply_stimulus(4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000);
        rst = 1'b0;
        check_output("rst_int_req", 32'(bus.int_req), 32'd0);
        check_output("rst_int_nmi", 32'(bus.int_nmi), 32'd0);
        check_output("rst_int_id", 32'(bus.int_id), 32'd0);
        check_output("rst_vector", bus.vector, 32'd0);
        check_output("rst_store_restore", 32'(bus.store_restore), 32'd0);
        check_output("rst_in_service", 32'(bus.in_service), 32'd0);
        check_output("rst_mask", 32'(bus.mask), 32'd0);

        // Mask write: the write cycle still arbitrates with the old mask
        $display("[TB] mask write");
        apply_stimulus(4'b0110, 0, 0, 1, 0, 0, 1, 4'b1111);
        check_output("mw_mask", 32'(bus.mask), 32'hF);
        check_output("mw_old_mask_req", 32'(bus.int_req), 32'd0);
        apply_stimulus(4'b0110, 0, 0, 1, 0, 0, 0, 4'b0000);
        check_output("mw_int_req", 32'(bus.int_req), 32'd1);
        check_output("mw_int_id", 32'(bus.int_id), 32'd1);
        check_output("mw_vector", bus.vector, 32'h0000_0110);
        check_output("mw_int_nmi", 32'(bus.int_nmi), 32'd0);
        // Higher-priority arrival and stray eret in REQ change nothing
        apply_stimulus(4'b0001, 0, 0, 1, 0, 1, 0, 4'b0000);
        check_output("req_hold_req", 32'(bus.int_req), 32'd1);
        check_output("req_hold_id", 32'(bus.int_id), 32'd1);
        check_output("req_eret_ign", 32'(bus.store_restore), 32'd0);

        // Full handshake
        $display("[TB] handshake");
        apply_stimulus(4'b0000, 0, 0, 1, 1, 0, 0, 4'b0000);
        check_output("hs_save_sr", 32'(bus.store_restore), 32'd1);
        check_output("hs_save_req", 32'(bus.int_req), 32'd0);
        check_output("hs_save_insvc", 32'(bus.in_service), 32'd0);
        apply_stimulus(4'b0001, 0, 0, 1, 0, 0, 0, 4'b0000);
        check_output("hs_svc_sr", 32'(bus.store_restore), 32'd0);
        check_output("hs_svc_insvc", 32'(bus.in_service), 32'd1);
        check_output("hs_svc_vector", bus.vector, 32'h0000_0110);
        apply_stimulus(4'b0001, 0, 0, 1, 1, 0, 0, 4'b0000);
        check_output("hs_nonest_req", 32'(bus.int_req), 32'd0);
        check_output("hs_nonest_insvc", 32'(bus.in_service), 32'd1);
        apply_stimulus(4'b0001, 0, 0, 1, 0, 1, 0, 4'b0000);
        check_output("hs_rest_sr", 32'(bus.store_restore), 32'd2);
        check_output("hs_rest_insvc", 32'(bus.in_service), 32'd1);
        apply_stimulus(4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000);
        check_output("hs_idle_req", 32'(bus.int_req), 32'd0);
        check_output("hs_idle_sr", 32'(bus.store_restore), 32'd0);
        check_output("hs_idle_insvc", 32'(bus.in_service), 32'd0);
        check_output("hs_idle_vector", bus.vector, 32'd0);
        check_output("hs_idle_id", 32'(bus.int_id), 32'd0);

        // Mask and busy blocking
        $display("[TB] mask and busy blocking");
        apply_stimulus(4'b0001, 0, 0, 0, 0, 0, 1, 4'b0000);
        check_output("mb_mask0", 32'(bus.mask), 32'd0);
        apply_stimulus(4'b0001, 0, 0, 1, 0, 0, 0, 4'b0000);
        check_output("mb_masked_req", 32'(bus.int_req), 32'd0);
        apply_stimulus(4'b0001, 0, 1, 1, 0, 0, 1, 4'b0001);
        check_output("mb_mask1", 32'(bus.mask), 32'd1);
        check_output("mb_oldmask_req", 32'(bus.int_req), 32'd0);
        apply_stimulus(4'b0001, 0, 1, 1, 0, 0, 0, 4'b0000);
        check_output("mb_busy_req", 32'(bus.int_req), 32'd0);
        apply_stimulus(4'b0001, 0, 0, 1, 0, 0, 0, 4'b0000);
        check_output("mb_req", 32'(bus.int_req), 32'd1);
        check_output("mb_vector", bus.vector, 32'h0000_0100);
        check_output("mb_id", 32'(bus.int_id), 32'd0);
        apply_stimulus(4'b0001, 0, 0, 1, 1, 0, 0, 4'b0000);
        check_output("mb_save_sr", 32'(bus.store_restore), 32'd1);
        apply_stimulus(4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000);
        check_output("mb_svc", 32'(bus.in_service), 32'd1);
        apply_stimulus(4'b0000, 0, 0, 1, 0, 1, 0, 4'b0000);
        check_output("mb_rest_sr", 32'(bus.store_restore), 32'd2);
        apply_stimulus(4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000);
        check_output("mb_idle_insvc", 32'(bus.in_service), 32'd0);

        // NMI priority and busy bypass; held nmi does not retrigger
        $display("[TB] nmi priority");
        apply_stimulus(4'b0001, 1, 1, 1, 0, 0, 0, 4'b0000);
        check_output("nmi_edge_req", 32'(bus.int_req), 32'd0);
        apply_stimulus(4'b0001, 1, 1, 1, 0, 0, 0, 4'b0000);
        check_output("nmi_req", 32'(bus.int_req), 32'd1);
        check_output("nmi_flag", 32'(bus.int_nmi), 32'd1);
        check_output("nmi_vector", bus.vector, 32'h0000_0080);
        apply_stimulus(4'b0001, 1, 1, 1, 1, 0, 0, 4'b0000);
        check_output("nmi_save_sr", 32'(bus.store_restore), 32'd1);
        apply_stimulus(4'b0001, 1, 1, 1, 0, 0, 0, 4'b0000);
        check_output("nmi_svc_flag", 32'(bus.int_nmi), 32'd1);
        apply_stimulus(4'b0001, 1, 1, 1, 0, 1, 0, 4'b0000);
        check_output("nmi_rest_sr", 32'(bus.store_restore), 32'd2);
        apply_stimulus(4'b0001, 1, 1, 1, 0, 0, 0, 4'b0000);
        check_output("nmi_idle_req", 32'(bus.int_req), 32'd0);
        apply_stimulus(4'b0001, 1, 1, 1, 0, 0, 0, 4'b0000);
        check_output("nmi_no_retrig", 32'(bus.int_req), 32'd0);
        apply_stimulus(4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000);
        check_output("nmi_fall_req", 32'(bus.int_req), 32'd0);

        // NMI arriving while source 2 is in service
        $display("[TB] nmi during service");
        apply_stimulus(4'b0100, 0, 0, 0, 0, 0, 1, 4'b0100);
        check_output("ns_mask", 32'(bus.mask), 32'h4);
        apply_stimulus(4'b0100, 0, 0, 1, 0, 0, 0, 4'b0000);
        check_output("ns_req_id", 32'(bus.int_id), 32'd2);
        check_output("ns_req_vector", bus.vector, 32'h0000_0120);
        apply_stimulus(4'b0100, 0, 0, 1, 1, 0, 0, 4'b0000);
        apply_stimulus(4'b0100, 0, 0, 1, 0, 0, 0, 4'b0000);
        apply_stimulus(4'b0100, 1, 0, 1, 0, 0, 0, 4'b0000);
        check_output("ns_svc_insvc", 32'(bus.in_service), 32'd1);
        check_output("ns_svc_nmi", 32'(bus.int_nmi), 32'd0);
        apply_stimulus(4'b0100, 0, 0, 1, 0, 0, 0, 4'b0000);
        check_output("ns_svc_id", 32'(bus.int_id), 32'd2);
        check_output("ns_svc_req", 32'(bus.int_req), 32'd0);
        apply_stimulus(4'b0000, 0, 0, 1, 0, 1, 0, 4'b0000);
        check_output("ns_rest_sr", 32'(bus.store_restore), 32'd2);
        check_output("ns_rest_nmi", 32'(bus.int_nmi), 32'd0);
        apply_stimulus(4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000);
        check_output("ns_idle_req", 32'(bus.int_req), 32'd0);
        apply_stimulus(4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000);
        check_output("ns_nmi_req", 32'(bus.int_req), 32'd1);
        check_output("ns_nmi_flag", 32'(bus.int_nmi), 32'd1);
        check_output("ns_nmi_vector", bus.vector, 32'h0000_0080);
        apply_stimulus(4'b0000, 0, 0, 1, 1, 0, 0, 4'b0000);
        check_output("ns_save_sr", 32'(bus.store_restore), 32'd1);

        // Reset during SAVE
        $display("[TB] reset mid-operation");
        rst = 1'b1;
        apply_stimulus(4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000);
        check_output("mr_sr", 32'(bus.store_restore), 32'd0);
        check_output("mr_req", 32'(bus.int_req), 32'd0);
        check_output("mr_insvc", 32'(bus.in_service), 32'd0);
        check_output("mr_mask", 32'(bus.mask), 32'd0);
        check_output("mr_nmi", 32'(bus.int_nmi), 32'd0);
        rst = 1'b0;
        apply_stimulus(4'b0100, 0, 0, 1, 0, 0, 0, 4'b0000);
        check_output("mr_after_req", 32'(bus.int_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_priority_controller.md
Name: irq_priority_controller

Overview:
- Parametrised successor to the single-line interrupt state unit of the multi-cycle MIPS core.
- Accepts N_SRC level-sensitive maskable interrupt lines plus one edge-detected non-maskable interrupt (NMI).
- Arbitrates by fixed priority and requests service from the control unit only at instruction boundaries.
- Sequences context save/restore through the 2-bit store/restore bus shared by the PC and register file, and supplies a 32-bit handler vector for the PC source mux.

Parameters:
- N_SRC, 4, number of maskable interrupt sources; legal range 1..16.
- ID_W, 2, width of the source index; must equal ceil(log2(N_SRC)), with a minimum of 1.
- VECTOR_BASE, 32'h0000_0100, handler address of source 0.
- VECTOR_STRIDE, 32'h0000_0010, address spacing between consecutive source handlers.
- NMI_VECTOR, 32'h0000_0080, handler address of the NMI.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- irq  in  N_SRC  level-sensitive maskable interrupt lines; bit 0 has the highest priority.
- nmi  in  1  non-maskable interrupt; acts on its rising edge.
- cpu_busy  in  1  when 1, blocks maskable acceptance; does not block the NMI.
- instr_boundary  in  1  high while the control FSM is in its fetch state.
- int_ack  in  1  control unit accepts the current request.
- eret  in  1  one-cycle return-from-interrupt strobe.
- mask_we  in  1  mask register write enable.
- mask_wdata  in  N_SRC  new mask value; 1 = source enabled.
- int_req  out  1  interrupt request to the control unit.
- int_nmi  out  1  current request or service is the NMI.
- int_id  out  ID_W  index of the source being requested or serviced.
- vector  out  32  handler address; valid while int_req or in_service is 1.
- store_restore  out  2  00 = idle, 01 = store context, 10 = restore context; 11 is never driven.
- in_service  out  1  a handler is executing.
- mask  out  N_SRC  current mask register.

Behaviour:
- Reset values: all outputs 0. The mask register resets to all zeros, so every maskable source is disabled. The NMI pending flag and the edge-detect register both reset to 0.
- Synchronous reset applied mid-operation (any state) returns the FSM to IDLE in the next cycle. store_restore is 00 from that cycle, and no save or restore is completed.
- NMI edge detection: nmi_d is nmi registered by one cycle. nmi_pend is set when nmi=1 and nmi_d=0. nmi_pend is cleared when the NMI is accepted in REQ. A new edge in the same cycle as that clear leaves nmi_pend set.
- Maskable candidates: cand = irq & mask. Winner = lowest set index of cand.
- Mask writes: a write with mask_we takes effect the next cycle. Arbitration in the write cycle uses the old mask.
- FSM states: IDLE, REQ, SAVE, SERVICE, RESTORE.
- IDLE:
  - Acceptance requires instr_boundary=1.
  - If nmi_pend=1, go to REQ with int_nmi=1 and vector=NMI_VECTOR. cpu_busy is ignored.
  - Otherwise, if cand is non-zero and cpu_busy=0, go to REQ with int_nmi=0, int_id=winner and vector = VECTOR_BASE + winner*VECTOR_STRIDE. Arithmetic is modulo 2^32.
  - int_id and vector are latched on entry to REQ and held until the FSM returns to IDLE.
- REQ:
  - int_req=1.
  - The latched request is held even if its irq line drops or is masked afterwards.
  - A higher-priority arrival does not replace the latched request.
  - When int_ack=1, go to SAVE. This clears nmi_pend if int_nmi=1.
- SAVE: exactly one cycle. int_req=0 and store_restore=01. Then go to SERVICE.
- SERVICE:
  - in_service=1.
  - No nesting: new maskable or NMI events only accumulate.
  - When eret=1, go to RESTORE.
- RESTORE: exactly one cycle. store_restore=10 and in_service stays 1. Then go to IDLE.
- Latency:
  - Boundary cycle with a qualifying event to int_req=1: 1 cycle.
  - int_ack to store_restore=01: 1 cycle.
  - eret to store_restore=10: 1 cycle.
  - Back-to-back service: a pending event may be accepted in the first IDLE cycle after RESTORE if instr_boundary=1.
- Ignored strobes: eret in IDLE, REQ or SAVE is ignored. int_ack outside REQ is ignored.
- Maskable sources are not latched: a line that drops before acceptance is lost. The source owns clearing its line.

Test Plan:
- Mask write: reset, then mask_we=1 with mask_wdata=4'b1111; irq=4'b0110 with instr_boundary=1 and cpu_busy=0 → the next cycle int_req=1, int_id=1 and vector=32'h0000_0110.
- Mask and busy blocking: irq=4'b0001 with mask=4'b0000 → int_req stays 0. With mask=4'b0001 and cpu_busy=1 → still 0. Drop cpu_busy → int_req=1, vector=32'h0000_0100.
- Full handshake: int_req=1, then int_ack pulse → the next cycle store_restore=01 for exactly 1 cycle, then in_service=1. An eret pulse → store_restore=10 for 1 cycle, then all outputs 0.
- NMI priority and busy bypass: nmi 0→1 together with irq=4'b0001 and cpu_busy=1 → int_nmi=1, vector=32'h0000_0080. Holding nmi high afterwards does not re-trigger after eret.
- NMI during service: nmi rising edge during SERVICE of source 2 → no change until RESTORE. The first boundary in IDLE then gives int_nmi=1.
- Reset mid-operation: assert reset in the SAVE cycle → the next cycle store_restore=00, int_req=0, in_service=0 and mask=0.
